// File: rtl/alu_seq_pipe.sv
// alu_seq_pipe
// Two-stage pipelined ALU with multiply and a multiply-accumulate register.
// Opcodes 0-3 (ADD, OR, SUB, XOR) behave as on the older 4-bit sequential ALU.
// Stage 1 captures the operands. Stage 2 computes the result, registers
// out/zero/carry and updates acc.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   in_valid   A/B/opcode are valid this cycle
//   A, B       unsigned operands, WIDTH bits
//   opcode     0 ADD, 1 OR, 2 SUB, 3 XOR, 4 AND, 5 MUL, 6 MAC, 7 RDACC
//   acc_clr    accumulator clear, sampled on the edge that retires stage 2
//   out_valid  out/zero/carry hold a new result this cycle
//   out        result, 2*WIDTH bits
//   zero       out == 0 for the current result
//   carry      carry / borrow / accumulator-wrap flag
//   acc        accumulator value
module alu_seq_pipe #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           opcode,
    input  logic                 acc_clr,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   out,
    output logic                 zero,
    output logic                 carry,
    output logic [2*WIDTH-1:0]   acc
);

    localparam int OW = 2 * WIDTH;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_OR    = 3'd1,
        OP_SUB   = 3'd2,
        OP_XOR   = 3'd3,
        OP_AND   = 3'd4,
        OP_MUL   = 3'd5,
        OP_MAC   = 3'd6,
        OP_RDACC = 3'd7
    } op_e;

    logic             vld_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;
    op_e              op_p1;

    logic [OW-1:0]    a_x;
    logic [OW-1:0]    b_x;
    logic [OW-1:0]    prod;
    logic [OW-1:0]    sum;
    logic [OW-1:0]    diff;
    logic [OW-1:0]    acc_base;
    logic [OW:0]      mac_sum;
    logic [OW-1:0]    res;
    logic             cy;
    logic [OW-1:0]    acc_nxt;

    // ---- stage 1: operand capture ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
            a_p1   <= '0;
            b_p1   <= '0;
            op_p1  <= OP_ADD;
        end else begin
            vld_p1 <= in_valid;
            a_p1   <= A;
            b_p1   <= B;
            op_p1  <= op_e'(opcode);
        end
    end

    // ---- stage 2: compute from stage-1 registers ----
    always_comb begin
        a_x  = {{WIDTH{1'b0}}, a_p1};
        b_x  = {{WIDTH{1'b0}}, b_p1};
        // Operands are zero-extended to OW bits, so the product never truncates.
        prod = a_x * b_x;
        sum  = a_x + b_x;
        diff = a_x - b_x;
        // A clear in the same cycle as a MAC restarts accumulation from zero.
        acc_base = acc_clr ? '0 : acc;
        mac_sum  = {1'b0, acc_base} + {1'b0, prod};

        res = '0;
        cy  = 1'b0;
        case (op_p1)
            OP_ADD:   begin res = sum;  cy = sum[WIDTH]; end
            OP_OR:    res = a_x | b_x;
            OP_SUB:   begin res = diff; cy = (a_p1 < b_p1); end
            OP_XOR:   res = a_x ^ b_x;
            OP_AND:   res = a_x & b_x;
            OP_MUL:   res = prod;
            OP_MAC:   begin res = mac_sum[OW-1:0]; cy = mac_sum[OW]; end
            OP_RDACC: res = acc;   // old value, even if a clear lands this cycle
            default:  res = '0;
        endcase

        acc_nxt = acc;
        if (vld_p1 && (op_p1 == OP_MAC)) begin
            acc_nxt = mac_sum[OW-1:0];
        end else if (acc_clr) begin
            acc_nxt = '0;
        end
    end

    // ---- stage 2 registers: result, flags, accumulator ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            acc       <= '0;
        end else begin
            out_valid <= vld_p1;
            acc       <= acc_nxt;
            // Bubbles leave the previous result and flags on the port.
            if (vld_p1) begin
                out   <= res;
                zero  <= (res == '0);
                carry <= cy;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_pipe.sv
// Scoreboard bench for alu_seq_pipe at WIDTH=4.
// The driver pushes the expected result of each valid op into a queue. A
// monitor on the falling edge pops and compares whenever out_valid is high,
// and checks that out/zero/carry hold during bubbles.
module tb_alu_seq_pipe;

    localparam int W  = 4;
    localparam int OW = 2 * W;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [2:0]    opcode;
    logic          acc_clr;
    logic          out_valid;
    logic [OW-1:0] out;
    logic          zero;
    logic          carry;
    logic [OW-1:0] acc;

    alu_seq_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out       (out),
        .zero      (zero),
        .carry     (carry),
        .acc       (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [OW-1:0] out;
        logic          carry;
        logic [OW-1:0] acc;
        int            due;
    } exp_t;

    exp_t q[$];

    int n_chk  = 0;
    int n_fail = 0;

    logic [OW-1:0] last_out   = '0;
    logic          last_zero  = 1'b0;
    logic          last_carry = 1'b0;
    logic          pend_clr   = 1'b0;
    int            macc       = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Hand-computed directed vectors: valid, a, b, op, clr, out, carry, acc after.
    typedef struct {
        int v, a, b, op, clr, eo, ec, ea;
    } vec_t;

    vec_t dir [0:24] = '{
        '{1,  5,  5, 0, 0,  10, 0,   0},   // first op after reset
        '{1, 15,  1, 0, 0,  16, 1,   0},   // ADD carry out of bit W
        '{1,  3,  5, 2, 0, 254, 1,   0},   // SUB borrow -> 8'hFE
        '{1, 12, 10, 1, 0,  14, 0,   0},   // OR
        '{1, 12, 10, 3, 0,   6, 0,   0},   // XOR
        '{1, 15, 15, 5, 0, 225, 0,   0},   // MUL full product
        '{1,  9,  6, 4, 0,   0, 0,   0},   // AND -> zero
        '{1,  0,  0, 2, 0,   0, 0,   0},   // SUB equal -> zero, no borrow
        '{1, 15, 15, 6, 0, 225, 0, 225},   // MAC
        '{1, 15, 15, 6, 0, 194, 1, 194},   // MAC wraps
        '{1,  0,  0, 7, 0, 194, 0, 194},   // RDACC
        '{1,  0,  0, 7, 1, 194, 0,   0},   // RDACC with clear: old value out
        '{1, 10, 10, 6, 0, 100, 0, 100},   // MAC to 100
        '{1,  2,  3, 6, 1,   6, 0,   6},   // clear + MAC
        '{1,  0,  0, 7, 1,   6, 0,   0},   // clear + RDACC
        '{1,  0,  0, 7, 0,   0, 0,   0},   // RDACC after clear
        '{1,  3,  3, 6, 0,   9, 0,   9},   // MAC
        '{1,  1,  2, 0, 1,   3, 0,   0},   // clear alongside ADD
        '{1,  2,  2, 6, 0,   4, 0,   4},   // MAC
        '{0,  0,  0, 0, 1,   0, 0,   0},   // bubble with clear
        '{1,  0,  0, 7, 0,   0, 0,   0},   // RDACC sees cleared acc
        '{1,  1,  1, 0, 0,   2, 0,   0},   // ADD
        '{0,  0,  0, 0, 0,   0, 0,   0},   // bubble, out holds 2
        '{1,  2,  2, 0, 0,   4, 0,   0},   // ADD
        '{1,  7,  9, 6, 0,  63, 0,  63}    // MAC leaves acc nonzero
    };

    task automatic issue(input int v, a, b, op, clr, eo, ec, ea);
        exp_t e;
        rst      = 1'b1;
        in_valid = v[0];
        A        = a[W-1:0];
        B        = b[W-1:0];
        opcode   = op[2:0];
        acc_clr  = pend_clr;     // clear belongs to the op now in stage 2
        pend_clr = clr[0];
        if (v != 0) begin
            e.out   = eo[OW-1:0];
            e.carry = ec[0];
            e.acc   = ea[OW-1:0];
            e.due   = cyc + 2;
            q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic clear_state();
        q.delete();
        macc       = 0;
        pend_clr   = 1'b0;
        last_out   = '0;
        last_zero  = 1'b0;
        last_carry = 1'b0;
    endtask

    // Two reset cycles with a valid ADD(5,5) on the inputs that must be ignored.
    task automatic do_reset();
        rst      = 1'b0;
        in_valid = 1'b1;
        A        = 4'd5;
        B        = 4'd5;
        opcode   = 3'd0;
        acc_clr  = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_out",       out,       0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_acc",       acc,       0);
        chk("rst_zero",      zero,      0);
        chk("rst_carry",     carry,     0);
        clear_state();
    endtask

    task automatic model(input int v, a, b, op, clr, output int eo, ec, ea);
        int m, s;
        m  = 1 << OW;
        eo = 0;
        ec = 0;
        case (op)
            0: begin eo = (a + b) % m; ec = ((a + b) >> W) & 1; end
            1: eo = a | b;
            2: begin eo = (a - b + m) % m; ec = (a < b) ? 1 : 0; end
            3: eo = a ^ b;
            4: eo = a & b;
            5: eo = a * b;
            6: begin
                s  = (clr != 0 ? 0 : macc) + a * b;
                eo = s % m;
                ec = (s >= m) ? 1 : 0;
            end
            default: eo = macc;
        endcase
        if (v != 0 && op == 6) macc = eo;
        else if (clr != 0)     macc = 0;
        ea = macc;
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1) begin
            if (out_valid !== 1'b0) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", out_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk("latency", cyc,   e.due);
                    chk("out",     out,   e.out);
                    chk("zero",    zero,  (e.out == '0));
                    chk("carry",   carry, e.carry);
                    chk("acc",     acc,   e.acc);
                    last_out   = e.out;
                    last_zero  = (e.out == '0);
                    last_carry = e.carry;
                end
            end else begin
                chk("hold_out",   out,   last_out);
                chk("hold_zero",  zero,  last_zero);
                chk("hold_carry", carry, last_carry);
            end
        end
    end

    initial begin
        int eo, ec, ea, v, a, b, op, clr;
        rst      = 1'b0;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        opcode   = '0;
        acc_clr  = 1'b0;

        do_reset();
        foreach (dir[i])
            issue(dir[i].v, dir[i].a, dir[i].b, dir[i].op, dir[i].clr,
                  dir[i].eo, dir[i].ec, dir[i].ea);
        issue(0, 0, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 0);

        // Mid-stream reset: a MAC enters stage 1, then reset lands with another op on the inputs.
        rst      = 1'b1;
        in_valid = 1'b1;
        A        = 4'd5;
        B        = 4'd5;
        opcode   = 3'd6;
        acc_clr  = 1'b0;
        @(posedge clk); #1;
        rst    = 1'b0;
        A      = 4'd7;
        B      = 4'd7;
        opcode = 3'd0;
        repeat (2) begin @(posedge clk); #1; end
        chk("midrst_acc",       acc,       0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out",       out,       0);
        clear_state();
        repeat (3) issue(0, 0, 0, 0, 0, 0, 0, 0);

        // Random ops against the reference model.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            v   = ($urandom_range(0, 3) != 0) ? 1 : 0;
            a   = $urandom_range(0, (1 << W) - 1);
            b   = $urandom_range(0, (1 << W) - 1);
            op  = $urandom_range(0, 7);
            clr = ($urandom_range(0, 7) == 0) ? 1 : 0;
            model(v, a, b, op, clr, eo, ec, ea);
            issue(v, a, b, op, clr, eo, ec, ea);
        end
        repeat (2) issue(0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #1;
        chk("drain_pending", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
